// File: rtl/phase_softmax_n.sv
// N-channel Delta-Sigma spike softmax with winner-driven lateral inhibition; rates/winner latched per window.
// Latency: spike 1 cycle after the Rel sample; rates with rate_valid on the cycle_start edge. Optional: PHASE_SOFTMAX_N_HYST_EN.
module phase_softmax_n #(
    parameter int N_CH          = 6,
    parameter int REL_W         = 8,
    parameter int ACC_W         = 10,
    parameter int CNT_W         = 8,
    parameter int THRESHOLD     = 256,
    parameter int INHIBIT_GAIN  = 4,
    parameter int INHIBIT_SHIFT = 4,
    parameter int HYST_MARGIN   = 16,
    localparam int WIN_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cycle_start,
    input  logic                    en,
    input  logic [N_CH*REL_W-1:0]   rel_vec,
    output logic [N_CH-1:0]         spike_vec,
    output logic [N_CH*CNT_W-1:0]   rate_vec,
    output logic [WIN_W-1:0]        winner_out,
    output logic                    rate_valid
);

    localparam int PROD_W = REL_W + ACC_W + 32;

    logic [REL_W-1:0]  rel      [N_CH];
    logic [ACC_W-1:0]  acc      [N_CH];
    logic [CNT_W-1:0]  cnt      [N_CH];
    logic [REL_W:0]    diff     [N_CH];
    logic [PROD_W-1:0] prod     [N_CH];
    logic [ACC_W-1:0]  inh      [N_CH];
    logic [ACC_W:0]    a_sum    [N_CH];
    logic [ACC_W:0]    a_net    [N_CH];
    logic [ACC_W-1:0]  acc_nxt  [N_CH];
    logic              fire     [N_CH];
    logic [WIN_W-1:0]  win;
    logic [WIN_W-1:0]  ref_win;
    logic [REL_W-1:0]  win_rel;
    logic [REL_W-1:0]  ref_rel;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        for (int i = 0; i < N_CH; i++) rel[i] = rel_vec[i*REL_W +: REL_W];
        win     = '0;
        win_rel = rel[0];
        for (int i = 1; i < N_CH; i++) begin
            if (rel[i] > win_rel) begin
                win     = WIN_W'(i);
                win_rel = rel[i];
            end
        end
    end

`ifdef PHASE_SOFTMAX_N_HYST_EN
    logic [WIN_W-1:0] cur_win;
    logic             hyst_switch;

    assign hyst_switch = {1'b0, win_rel} > ({1'b0, rel[cur_win]} + (REL_W+1)'(HYST_MARGIN));
    assign ref_win     = cur_win;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cur_win <= '0;
        else if (!cycle_start && en && hyst_switch)
            cur_win <= win;
    end
`else
    assign ref_win = win;
`endif

    assign ref_rel = rel[ref_win];

    // A sticky winner can sit below another channel; such channels get no inhibition.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            diff[i] = {1'b0, ref_rel} - {1'b0, rel[i]};
            if (diff[i][REL_W])
                diff[i] = '0;
            prod[i]    = PROD_W'(diff[i] >> INHIBIT_SHIFT) * PROD_W'(INHIBIT_GAIN);
            inh[i]     = (prod[i] > PROD_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : prod[i][ACC_W-1:0];
            a_sum[i]   = {1'b0, acc[i]} + (ACC_W+1)'(rel[i]);
            a_net[i]   = (a_sum[i] >= {1'b0, inh[i]}) ? (a_sum[i] - {1'b0, inh[i]}) : '0;
            fire[i]    = a_net[i] >= (ACC_W+1)'(THRESHOLD);
            acc_nxt[i] = fire[i] ? ACC_W'(a_net[i] - (ACC_W+1)'(THRESHOLD)) : a_net[i][ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            rate_vec   <= '0;
            spike_vec  <= '0;
            winner_out <= '0;
            rate_valid <= 1'b0;
        end else if (cycle_start) begin
            for (int i = 0; i < N_CH; i++) begin
                rate_vec[i*CNT_W +: CNT_W] <= cnt[i];
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            spike_vec  <= '0;
            winner_out <= ref_win;
            rate_valid <= 1'b1;
        end else if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                spike_vec[i] <= fire[i];
                acc[i]       <= acc_nxt[i];
                if (fire[i] && (cnt[i] != {CNT_W{1'b1}}))
                    cnt[i] <= cnt[i] + 1'b1;
            end
            rate_valid <= 1'b0;
        end else begin
            spike_vec  <= '0;
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_softmax_n.sv
// Bench for phase_softmax_n: default and CNT_W=4 instances share stimulus; a cycle-level model checks every edge.
module tb_phase_softmax_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cycle_start = 1'b0;
    logic        en = 1'b0;
    logic [47:0] rel_vec = '0;
    logic [5:0]  spike_vec, spike4;
    logic [47:0] rate_vec;
    logic [23:0] rate4;
    logic [2:0]  winner_out, winner4;
    logic        rate_valid, rv4;

    int checks = 0;
    int errors = 0;

    phase_softmax_n dut (
        .clk(clk), .rst_n(rst_n), .cycle_start(cycle_start), .en(en), .rel_vec(rel_vec),
        .spike_vec(spike_vec), .rate_vec(rate_vec), .winner_out(winner_out), .rate_valid(rate_valid)
    );

    phase_softmax_n #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cycle_start(cycle_start), .en(en), .rel_vec(rel_vec),
        .spike_vec(spike4), .rate_vec(rate4), .winner_out(winner4), .rate_valid(rv4)
    );

    always #5 clk = ~clk;

    // Reference state: plain integers, one accumulator per channel, two counter widths.
    int cur_rel [6];
    int m_acc [6], m_cnt [6], m_cnt4 [6], m_rate [6], m_rate4 [6], m_spk [6];
    int m_win, m_rv, m_cur;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit cs, input bit e);
        int w, rw, d, inh, a;
        w = 0;
        for (int i = 1; i < 6; i++) if (cur_rel[i] > cur_rel[w]) w = i;
`ifdef PHASE_SOFTMAX_N_HYST_EN
        rw = m_cur;
`else
        rw = w;
`endif
        if (!r) begin
            for (int i = 0; i < 6; i++) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_cnt4[i] = 0;
                m_rate[i] = 0; m_rate4[i] = 0; m_spk[i] = 0;
            end
            m_win = 0; m_rv = 0; m_cur = 0;
        end else if (cs) begin
            for (int i = 0; i < 6; i++) begin
                m_rate[i] = m_cnt[i]; m_rate4[i] = m_cnt4[i];
                m_acc[i] = 0; m_cnt[i] = 0; m_cnt4[i] = 0; m_spk[i] = 0;
            end
            m_win = rw; m_rv = 1;
        end else if (e) begin
            for (int i = 0; i < 6; i++) begin
                d = cur_rel[rw] - cur_rel[i];
                if (d < 0) d = 0;
                inh = (d / 16) * 4;
                if (inh > 1023) inh = 1023;
                a = m_acc[i] + cur_rel[i] - inh;
                if (a < 0) a = 0;
                if (a >= 256) begin
                    m_spk[i] = 1;
                    m_acc[i] = a - 256;
                    m_cnt[i]  = (m_cnt[i]  < 255) ? m_cnt[i]  + 1 : 255;
                    m_cnt4[i] = (m_cnt4[i] < 15)  ? m_cnt4[i] + 1 : 15;
                end else begin
                    m_spk[i] = 0;
                    m_acc[i] = a;
                end
            end
            if (cur_rel[w] > cur_rel[m_cur] + 16) m_cur = w;
            m_rv = 0;
        end else begin
            for (int i = 0; i < 6; i++) m_spk[i] = 0;
            m_rv = 0;
        end
    endtask

    task automatic compare_all();
        logic [47:0] e_rate;
        logic [23:0] e_rate4;
        logic [5:0]  e_spk;
        for (int i = 0; i < 6; i++) begin
            e_rate[i*8 +: 8]  = 8'(m_rate[i]);
            e_rate4[i*4 +: 4] = 4'(m_rate4[i]);
            e_spk[i]          = m_spk[i][0];
        end
        check("spike_vec", spike_vec, e_spk);
        check("spike_vec_cnt4", spike4, e_spk);
        check("rate_vec", rate_vec, e_rate);
        check("rate_vec_cnt4", rate4, e_rate4);
        check("winner_out", winner_out, m_win);
        check("winner_out_cnt4", winner4, m_win);
        check("rate_valid", rate_valid, m_rv);
        check("rate_valid_cnt4", rv4, m_rv);
    endtask

    task automatic step(input bit r, input bit cs, input bit e);
        rst_n = r; cycle_start = cs; en = e;
        for (int i = 0; i < 6; i++) rel_vec[i*8 +: 8] = 8'(cur_rel[i]);
        @(posedge clk);
        model(r, cs, e);
        #1;
        compare_all();
    endtask

    task automatic set_rel(input logic [47:0] v);
        for (int i = 0; i < 6; i++) cur_rel[i] = int'(v[i*8 +: 8]);
    endtask

    typedef struct packed {
        logic [47:0] rel;
        logic [15:0] cycles;
        logic [47:0] rate;
        logic [2:0]  win;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vec_t v;
        logic [7:0] r8;

        vecs[0] = '{rel: {6{8'd128}}, cycles: 16, rate: {6{8'd8}}, win: 3'd0};
        vecs[1] = '{rel: {{5{8'd40}}, 8'd200}, cycles: 32, rate: {{5{8'd0}}, 8'd25}, win: 3'd0};
        vecs[2] = '{rel: {8'd100, 8'd180, 8'd100, 8'd180, 8'd100, 8'd100}, cycles: 8,
                    rate: {8'd2, 8'd5, 8'd2, 8'd5, 8'd2, 8'd2}, win: 3'd2};
        vecs[3] = '{rel: {{5{8'd0}}, 8'd255}, cycles: 40, rate: {{5{8'd0}}, 8'd39}, win: 3'd0};

        for (int i = 0; i < 6; i++) cur_rel[i] = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            v = vecs[k];
            step(0, 0, 0);
            set_rel(v.rel);
            for (int c = 0; c < int'(v.cycles); c++) step(1, 0, 1);
            step(1, 1, 1);
`ifndef PHASE_SOFTMAX_N_HYST_EN
            for (int i = 0; i < 6; i++) begin
                r8 = v.rate[i*8 +: 8];
                check($sformatf("table%0d_rate%0d", k, i), rate_vec[i*8 +: 8], r8);
                check($sformatf("table%0d_rate4_%0d", k, i), rate4[i*4 +: 4], (r8 > 15) ? 15 : r8);
            end
            check($sformatf("table%0d_winner", k), winner_out, v.win);
`endif
            check($sformatf("table%0d_valid", k), rate_valid, 1);
            step(1, 1, 0);
            check($sformatf("table%0d_b2b_rate", k), rate_vec, 0);
            step(1, 0, 0);
            check($sformatf("table%0d_valid_drop", k), rate_valid, 0);
        end

        // Reset in the middle of a window after a non-zero latch.
        step(0, 0, 0);
        set_rel({6{8'd128}});
        for (int c = 0; c < 16; c++) step(1, 0, 1);
        step(1, 1, 0);
        for (int c = 0; c < 10; c++) step(1, 0, 1);
        step(0, 0, 1);
        check("midreset_rate", rate_vec, 0);
        check("midreset_spike", spike_vec, 0);
        check("midreset_valid", rate_valid, 0);
        for (int c = 0; c < 6; c++) step(1, 0, 1);
        step(1, 1, 0);
        check("postreset_rate", rate_vec, {6{8'd3}});

        // Winner switching with a small Rel lead.
        step(0, 0, 0);
        set_rel({{4{8'd0}}, 8'd160, 8'd150});
        for (int c = 0; c < 3; c++) step(1, 0, 1);
        step(1, 1, 0);
`ifdef PHASE_SOFTMAX_N_HYST_EN
        check("hyst_hold_winner", winner_out, 0);
`else
        check("plain_winner_160", winner_out, 1);
`endif
        set_rel({{4{8'd0}}, 8'd170, 8'd150});
        step(1, 0, 1);
        step(1, 1, 0);
        check("winner_170", winner_out, 1);

        // Randomised traffic.
        step(0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < 6; i++) cur_rel[i] = int'($urandom_range(0, 255));
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
